// File: rtl/order_fetch_if.sv
// rtl/order_fetch_if.sv - instruction memory read port (request/acknowledge)
interface order_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/order_fetch.sv
// rtl/order_fetch.sv - instruction fetch stage; ORDER_FETCH_PREFETCH_EN selects a 2-deep prefetch buffer
module order_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  order_fetch_if.master imem,
  input  logic          isStop,
  input  logic          jump_en,
  input  logic [31:0]   jump_addr,
  input  logic          irq,
  input  logic [7:0]    irq_num,
  output logic [31:0]   order,
  output logic [31:0]   thisOrderAddress,
  output logic          this_isRunning,
  output logic          interrupt,
  output logic [7:0]    interrupt_num
);

`ifdef ORDER_FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [1:0]  count, count_nxt;
  logic [1:0]  occ_base;
  logic        push, pop;
  logic [31:0] buf_data [DEPTH];
  logic [31:0] buf_addr [DEPTH];
  logic        irq_pend;
  logic [7:0]  irq_pend_num;
  logic        tag;
  logic [7:0]  tag_num;

  assign imem.mem_req  = (state != S_IDLE);
  assign imem.mem_addr = addr_q;

  // A pending interrupt wins over a same-cycle request; otherwise the fresh one tags the pop.
  assign tag     = irq_pend | irq;
  assign tag_num = irq_pend ? irq_pend_num : irq_num;

  // Buffer bookkeeping: a redirect flushes, data returned for a redirected request is dropped.
  always_comb begin
    pop       = !jump_en && !isStop && (count != 2'd0);
    push      = (state == S_REQ) && imem.mem_ack && !jump_en;
    occ_base  = count - {1'b0, pop};
    count_nxt = jump_en ? 2'd0 : occ_base + {1'b0, push};
  end

  // Fetch FSM next state, fetch PC and the held request address.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr_q;
    case (state)
      S_IDLE: begin
        if (jump_en) pc_nxt = jump_addr;
        addr_nxt = pc_nxt;
        if (count_nxt < DEPTH_C) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem.mem_ack) begin
          pc_nxt    = jump_en ? jump_addr : pc + 32'd4;
          addr_nxt  = pc_nxt;
          state_nxt = (count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
        end else if (jump_en) begin
          // The bus request must complete at its original address before refetching.
          pc_nxt    = jump_addr;
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (jump_en) pc_nxt = jump_addr;
        if (imem.mem_ack) begin
          addr_nxt  = pc_nxt;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      count  <= 2'd0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      addr_q <= addr_nxt;
      count  <= count_nxt;
    end
  end

  // Shift buffer: head is entry 0, a pop shifts down and a push lands after the survivors.
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        buf_data[i] <= buf_data[i+1];
        buf_addr[i] <= buf_addr[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_base == 2'(i)) begin
          buf_data[i] <= imem.mem_data;
          buf_addr[i] <= addr_q;
        end
      end
    end
  end

  // Interrupt pending latch: first request wins until it is attached to a popped slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_pend     <= 1'b0;
      irq_pend_num <= 8'd0;
    end else if (pop) begin
      irq_pend <= 1'b0;
    end else if (irq && !irq_pend) begin
      irq_pend     <= 1'b1;
      irq_pend_num <= irq_num;
    end
  end

  // Decode slot register: redirect forces a bubble, stall holds, otherwise pop or bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      order            <= 32'd0;
      thisOrderAddress <= 32'd0;
      this_isRunning   <= 1'b0;
      interrupt        <= 1'b0;
      interrupt_num    <= 8'd0;
    end else if (jump_en) begin
      order          <= 32'd0;
      this_isRunning <= 1'b0;
      interrupt      <= 1'b0;
      interrupt_num  <= 8'd0;
    end else if (!isStop) begin
      if (count != 2'd0) begin
        order            <= buf_data[0];
        thisOrderAddress <= buf_addr[0];
        this_isRunning   <= 1'b1;
        interrupt        <= tag;
        interrupt_num    <= tag ? tag_num : 8'd0;
      end else begin
        order          <= 32'd0;
        this_isRunning <= 1'b0;
        interrupt      <= 1'b0;
        interrupt_num  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_order_fetch.sv
// tb/tb_order_fetch.sv - self-checking bench for order_fetch (table vectors plus scoreboard)
module tb_order_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef ORDER_FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        isStop, jump_en, irq;
  logic [31:0] jump_addr;
  logic [7:0]  irq_num;
  logic [31:0] order, thisOrderAddress;
  logic        this_isRunning, interrupt;
  logic [7:0]  interrupt_num;

  order_fetch_if bus();
  assign bus.mem_data = bus.mem_addr;

  order_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem(bus), .isStop(isStop), .jump_en(jump_en),
    .jump_addr(jump_addr), .irq(irq), .irq_num(irq_num), .order(order),
    .thisOrderAddress(thisOrderAddress), .this_isRunning(this_isRunning),
    .interrupt(interrupt), .interrupt_num(interrupt_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stop;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_run;
    logic [31:0] exp_order;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc, drop_addr, last_order, last_addr;
  logic        drop_pending, pend, last_run, last_int;
  logic [7:0]  pnum, last_num;
  int          ack_mode, wait_cnt, tagged_cnt;
  logic        seen_400, seen_zero, seen_rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc = RPC; drop_pending = 1'b0; drop_addr = 32'd0;
    pend = 1'b0; pnum = 8'd0;
    last_order = 32'd0; last_addr = 32'd0; last_run = 1'b0; last_int = 1'b0; last_num = 8'd0;
    wait_cnt = 0;
  endtask

  // One clock: memory model answers, expectations are formed, edge passes, outputs are compared.
  task automatic tick();
    logic req_b, ack_b, stop_b, jump_b, irq_b, popped;
    logic [31:0] addr_b, jaddr_b, exp_o;
    logic [7:0] inum_b, exp_n;
    logic exp_run, exp_int;
    if (ack_mode == 0) bus.mem_ack = 1'b1;
    else bus.mem_ack = bus.mem_req && (wait_cnt == 3);
    #1;
    req_b = bus.mem_req; ack_b = bus.mem_ack; addr_b = bus.mem_addr;
    stop_b = isStop; jump_b = jump_en; jaddr_b = jump_addr; irq_b = irq; inum_b = irq_num;
    popped = 1'b0;
    exp_run = last_run; exp_o = last_order; exp_int = last_int; exp_n = last_num;
    if (jump_b) begin
      exp_run = 1'b0; exp_o = 32'd0; exp_int = 1'b0; exp_n = 8'd0;
    end else if (!stop_b) begin
      if (exp_q.size() > 0) begin
        popped = 1'b1;
        exp_run = 1'b1;
        exp_o = exp_q.pop_front();
        last_addr = exp_o;
        exp_int = pend | irq_b;
        exp_n = pend ? pnum : inum_b;
        if (exp_o == 32'h400) seen_400 = 1'b1;
        if (exp_o == RPC) seen_rpc = 1'b1;
        pend = 1'b0;
      end else begin
        exp_run = 1'b0; exp_o = 32'd0; exp_int = 1'b0; exp_n = 8'd0;
      end
    end
    if (!popped && irq_b && !pend) begin
      pend = 1'b1; pnum = inum_b;
    end
    if (req_b && ack_b) begin
      chk("mem_addr_at_ack", addr_b, drop_pending ? drop_addr : exp_pc);
      if (drop_pending) drop_pending = 1'b0;
      else if (!jump_b) begin
        exp_q.push_back(exp_pc);
        if (exp_pc == 32'd0) seen_zero = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (jump_b) begin
      exp_q.delete();
      if (req_b && !ack_b && !drop_pending) begin
        drop_pending = 1'b1; drop_addr = exp_pc;
      end
      exp_pc = jaddr_b;
    end
    if (req_b && !ack_b) wait_cnt++;
    else wait_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("this_isRunning", {31'd0, this_isRunning}, {31'd0, exp_run});
    chk("order", order, exp_o);
    chk("thisOrderAddress", thisOrderAddress, last_addr);
    chk("interrupt", {31'd0, interrupt}, {31'd0, exp_int});
    if (exp_int) chk("interrupt_num", {24'd0, interrupt_num}, {24'd0, exp_n});
    if ((!stop_b || jump_b) && interrupt) tagged_cnt++;
    if (req_b && !ack_b) begin
      chk("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
      chk("mem_addr_held", bus.mem_addr, addr_b);
    end
    last_run = exp_run; last_order = exp_o; last_int = exp_int; last_num = exp_n;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, RPC);
    chk({tag, "_order"}, order, 32'd0);
    chk({tag, "_addr"}, thisOrderAddress, 32'd0);
    chk({tag, "_running"}, {31'd0, this_isRunning}, 32'd0);
    chk({tag, "_interrupt"}, {31'd0, interrupt}, 32'd0);
    chk({tag, "_interrupt_num"}, {24'd0, interrupt_num}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    logic found;
`ifdef ORDER_FETCH_PREFETCH_EN
    vt[0] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h000};
    vt[1] = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h000};
    vt[2] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h100};
    vt[3] = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h104};
    vt[4] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h108};
`else
    vt[0] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h000};
    vt[1] = '{1'b0, 1'b0, 32'h104, 1'b0, 32'h000};
    vt[2] = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h100};
    vt[3] = '{1'b0, 1'b0, 32'h108, 1'b0, 32'h000};
    vt[4] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h104};
`endif
    rst = 1'b0; isStop = 1'b0; jump_en = 1'b0; jump_addr = 32'd0; irq = 1'b0; irq_num = 8'd0;
    bus.mem_ack = 1'b0;
    ack_mode = 0; tagged_cnt = 0;
    seen_400 = 1'b0; seen_zero = 1'b0; seen_rpc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Cycle-exact start-up with memory acking every cycle.
    for (int i = 0; i < 5; i++) begin
      isStop = vt[i].stop;
      tick();
      chk("tbl_mem_req", {31'd0, bus.mem_req}, {31'd0, vt[i].exp_req});
      chk("tbl_mem_addr", bus.mem_addr, vt[i].exp_addr);
      chk("tbl_running", {31'd0, this_isRunning}, {31'd0, vt[i].exp_run});
      chk("tbl_order", order, vt[i].exp_order);
    end
    repeat (3) tick();

    // Stall mid-stream: outputs freeze, fetching stops once the buffer is full.
    isStop = 1'b1;
    repeat (4) tick();
    chk("stall_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("stall_fill", exp_q.size(), DEPTH);
    isStop = 1'b0;
    repeat (6) tick();

    // Slow memory, redirect while a request is waiting: stale word dropped.
    ack_mode = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.mem_req && wait_cnt == 1) found = 1'b1;
      else tick();
    end
    chk("jump_setup_found", {31'd0, found}, 32'd1);
    jump_en = 1'b1; jump_addr = 32'h400;
    tick();
    jump_en = 1'b0;
    for (int k = 0; k < 30 && !seen_400; k++) tick();
    chk("jump_target_seen", {31'd0, seen_400}, 32'd1);

    // Interrupt raised with empty buffer; a second request while pending is ignored.
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (exp_q.size() == 0 && bus.mem_req && wait_cnt == 0 && !drop_pending) found = 1'b1;
      else tick();
    end
    chk("irq_setup_found", {31'd0, found}, 32'd1);
    tagged_cnt = 0;
    irq = 1'b1; irq_num = 8'h21;
    tick();
    irq_num = 8'h55;
    tick();
    irq = 1'b0; irq_num = 8'h00;
    repeat (20) tick();
    chk("irq_tag_count", tagged_cnt, 1);

    // Fetch PC wraps past the top of the address space.
    ack_mode = 0;
    seen_zero = 1'b0;
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFF4;
    tick();
    jump_en = 1'b0;
    repeat (10) tick();
    chk("pc_wrap_seen", {31'd0, seen_zero}, 32'd1);

    // Asynchronous reset in the middle of an outstanding request.
    isStop = 1'b1; ack_mode = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.mem_req && exp_q.size() == DEPTH - 1) found = 1'b1;
      else tick();
    end
    chk("areset_setup_found", {31'd0, found}, 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("areset");
    @(negedge clk);
    rst = 1'b1; isStop = 1'b0; ack_mode = 0;
    model_reset();
    seen_rpc = 1'b0;
    repeat (8) tick();
    chk("restart_seen", {31'd0, seen_rpc}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
